a2d_rr_sched: RTL and testbench

A2D_RR_SCHED -- requirements
Module: a2d_rr_sched

---
 rtl/a2d_rr_sched_if.sv | 9 +
 rtl/a2d_rr_sched.sv | 96 +++++++++
 tb/tb_a2d_rr_sched.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/a2d_rr_sched_if.sv
// a2d_rr_sched_if: command/response handshake between the scheduler and the shared SPI master.
interface a2d_rr_sched_if;
    logic        wrt;
    logic [15:0] wt_data;
    logic        done;
    logic [15:0] rd_data;
    modport master (output wrt, wt_data, input done, rd_data);
    modport slave  (input wrt, wt_data, output done, rd_data);
endinterface

// File: rtl/a2d_rr_sched.sv
// a2d_rr_sched: round-robin A2D conversion scheduler over a shared SPI master.
// Each conversion is a command transaction, a one-cycle gap, then a read transaction.
module a2d_rr_sched #(
    parameter logic [2:0]  CH_LFT   = 3'd0,
    parameter logic [2:0]  CH_RGHT  = 3'd4,
    parameter logic [2:0]  CH_STEER = 3'd5,
    parameter logic [2:0]  CH_BATT  = 3'd6,
    parameter logic [15:0] TMO      = 16'd4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  nxt,
    a2d_rr_sched_if.master        spi,
    output logic [11:0]           lft_ld,
    output logic [11:0]           rght_ld,
    output logic [11:0]           steer_pot,
    output logic [11:0]           batt,
    output logic                  cnv_cmplt,
    output logic                  busy,
    output logic                  tmo_err
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CMD  = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;
    localparam logic [1:0] READ = 2'd3;

    logic [1:0]  state;
    logic [1:0]  ptr;
    logic [15:0] tmo_cnt;
    logic [2:0]  ch;
    logic        tmo_hit;
    logic        unused_hi;

    always_comb ch = ptr == 2'd0 ? CH_LFT : ptr == 2'd1 ? CH_RGHT : ptr == 2'd2 ? CH_STEER : CH_BATT;

    assign spi.wt_data = {2'b00, ch, 11'h000};
    assign busy        = state != IDLE;
    assign tmo_hit     = tmo_cnt == TMO - 16'd1;
    assign unused_hi   = ^spi.rd_data[15:12];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            tmo_cnt   <= 16'd0;
            lft_ld    <= 12'd0;
            rght_ld   <= 12'd0;
            steer_pot <= 12'd0;
            batt      <= 12'd0;
            spi.wrt   <= 1'b0;
            cnv_cmplt <= 1'b0;
            tmo_err   <= 1'b0;
        end else begin
            spi.wrt   <= 1'b0;
            cnv_cmplt <= 1'b0;
            case (state)
                IDLE: if (nxt) begin
                    spi.wrt <= 1'b1;
                    tmo_cnt <= 16'd0;
                    state   <= CMD;
                end
                CMD: if (spi.done) begin
                    state <= GAP;
                end else if (tmo_hit) begin
                    state   <= IDLE;
                    tmo_err <= 1'b1;
                    ptr     <= ptr + 2'd1;
                end else begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                end
                GAP: begin
                    spi.wrt <= 1'b1;
                    tmo_cnt <= 16'd0;
                    state   <= READ;
                end
                READ: if (spi.done) begin
                    case (ptr)
                        2'd0: lft_ld    <= spi.rd_data[11:0];
                        2'd1: rght_ld   <= spi.rd_data[11:0];
                        2'd2: steer_pot <= spi.rd_data[11:0];
                        2'd3: batt      <= spi.rd_data[11:0];
                    endcase
                    cnv_cmplt <= 1'b1;
                    ptr       <= ptr + 2'd1;
                    state     <= IDLE;
                end else if (tmo_hit) begin
                    state   <= IDLE;
                    tmo_err <= 1'b1;
                    ptr     <= ptr + 2'd1;
                end else begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_a2d_rr_sched.sv
// tb_a2d_rr_sched: directed scoreboard bench; an SPI responder pushes expected result sets,
// a negedge monitor pops them on each cnv_cmplt and checks wt_data on each wrt.
module tb_a2d_rr_sched;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        nxt_s, nxt_c, nxt;
    logic        done_r, done_m;
    logic [15:0] rd_r;
    logic [11:0] lft_ld, rght_ld, steer_pot, batt;
    logic        cnv_cmplt, busy, tmo_err;

    logic        hold, coin, inc, ph, prev_busy;
    logic [11:0] resp;
    logic [1:0]  mp;
    logic [11:0] shadow [4];
    logic [2:0]  ch_tab [4] = '{3'd0, 3'd4, 3'd5, 3'd6};
    logic [47:0] exp_q [$];
    logic [15:0] last_wt;
    int          n_chk = 0, n_fail = 0;
    int          wrt_cnt = 0, cnv_cnt = 0, starts = 0;

    a2d_rr_sched_if spi ();

    assign nxt         = nxt_s | nxt_c;
    assign spi.done    = done_r | done_m;
    assign spi.rd_data = rd_r;

    a2d_rr_sched dut (
        .clk(clk), .rst_n(rst_n), .nxt(nxt), .spi(spi),
        .lft_ld(lft_ld), .rght_ld(rght_ld), .steer_pot(steer_pot), .batt(batt),
        .cnv_cmplt(cnv_cmplt), .busy(busy), .tmo_err(tmo_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // SPI slave model: answers every wrt after two cycles; the second answer carries the result
    initial begin
        done_r = 1'b0; nxt_c = 1'b0; rd_r = 16'h0; ph = 1'b0; mp = 2'd0;
        for (int i = 0; i < 4; i++) shadow[i] = 12'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) ph = 1'b0;
            else if (spi.wrt && !hold) begin
                repeat (2) @(negedge clk);
                if (ph) begin
                    rd_r = {4'hF, resp};
                    shadow[mp] = resp;
                    exp_q.push_back({shadow[0], shadow[1], shadow[2], shadow[3]});
                    mp = mp + 2'd1;
                    nxt_c = coin;
                    if (inc) resp = resp + 12'h011;
                end else rd_r = 16'h0BAD;
                done_r = 1'b1;
                @(negedge clk);
                done_r = 1'b0;
                nxt_c = 1'b0;
                ph = ~ph;
            end
        end
    end

    initial prev_busy = 1'b0;
    always @(negedge clk) if (rst_n) begin
        if (spi.wrt) begin
            wrt_cnt++;
            if (!prev_busy) starts++;
            last_wt = spi.wt_data;
            check("wt_data", spi.wt_data, {2'b00, ch_tab[mp], 11'h000});
        end
        if (cnv_cmplt) begin
            cnv_cnt++;
            if (exp_q.size() == 0) check("unexpected_cnv", 1, 0);
            else check("results", {lft_ld, rght_ld, steer_pot, batt}, exp_q.pop_front());
        end
        prev_busy = busy;
    end

    task automatic wait_wrt(input string name);
        int k = 0;
        while (!spi.wrt && k < 20) begin @(negedge clk); k++; end
        check(name, spi.wrt, 1);
    endtask

    task automatic conv(input logic [11:0] v, input logic c);
        int base = cnv_cnt;
        int k = 0;
        resp = v; coin = c;
        nxt_s = 1'b1;
        @(negedge clk);
        nxt_s = 1'b0;
        while (cnv_cnt == base && k < 40) begin @(negedge clk); k++; end
        check("conv_done", cnv_cnt - base, 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int w0, c0, s0, n;
        rst_n = 1'b0; nxt_s = 1'b0; hold = 1'b0; coin = 1'b0; inc = 1'b0; resp = 12'h0; done_m = 1'b0;
        last_wt = 16'hFFFF;
        repeat (2) @(negedge clk);
        check("rst_regs", {lft_ld, rght_ld, steer_pot, batt}, 48'h0);
        check("rst_flags", {busy, tmo_err, spi.wrt, cnv_cmplt}, 4'h0);
        check("rst_wt_data", spi.wt_data, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);

        conv(12'hA5A, 0); conv(12'h123, 0); conv(12'h800, 0); conv(12'hFFF, 0);
        check("four_regs", {lft_ld, rght_ld, steer_pot, batt}, {12'hA5A, 12'h123, 12'h800, 12'hFFF});
        check("four_cnv", cnv_cnt, 4);
        check("four_wrt", wrt_cnt, 8);
        conv(12'h0FF, 0);
        check("wrap", {lft_ld, rght_ld, steer_pot, batt}, {12'h0FF, 12'h123, 12'h800, 12'hFFF});

        w0 = wrt_cnt; c0 = cnv_cnt;
        conv(12'h456, 1);
        repeat (3) @(negedge clk);
        check("coin_cnv", cnv_cnt - c0, 1);
        check("coin_wrt", wrt_cnt - w0, 2);
        check("coin_busy", busy, 0);
        conv(12'h789, 0); conv(12'hABC, 0);

        hold = 1'b1;
        nxt_s = 1'b1;
        @(negedge clk);
        nxt_s = 1'b0;
        n = 0;
        while (busy && n < 5000) begin @(negedge clk); n++; end
        check("tmo_window", (n >= 4090 && n <= 4100), 1);
        check("tmo_state", {busy, tmo_err, cnv_cmplt}, 3'b010);
        check("tmo_regs", {lft_ld, rght_ld, steer_pot, batt}, {12'h0FF, 12'h456, 12'h789, 12'hABC});
        mp = mp + 2'd1;
        hold = 1'b0;
        conv(12'h321, 0);
        check("tmo_next_ch", last_wt, 16'h2000);
        check("tmo_next_regs", {lft_ld, rght_ld, steer_pot, batt}, {12'h0FF, 12'h321, 12'h789, 12'hABC});

        w0 = wrt_cnt; c0 = cnv_cnt; s0 = starts;
        inc = 1'b1; resp = 12'h100;
        nxt_s = 1'b1;
        repeat (100) @(negedge clk);
        nxt_s = 1'b0;
        n = 0;
        while (busy && n < 50) begin @(negedge clk); n++; end
        inc = 1'b0;
        repeat (4) @(negedge clk);
        check("flood_busy", busy, 0);
        check("flood_2wrt", wrt_cnt - w0, 2 * (cnv_cnt - c0));
        check("flood_starts", starts - s0, cnv_cnt - c0);
        check("flood_count", (cnv_cnt - c0) >= 10, 1);
        check("flood_queue", exp_q.size(), 0);

        hold = 1'b1;
        nxt_s = 1'b1;
        @(negedge clk);
        nxt_s = 1'b0;
        wait_wrt("rst_cmd_wrt");
        repeat (2) @(negedge clk);
        done_m = 1'b1;
        @(negedge clk);
        done_m = 1'b0;
        @(negedge clk);
        wait_wrt("rst_read_wrt");
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_regs", {lft_ld, rght_ld, steer_pot, batt}, 48'h0);
        check("rst_mid_flags", {busy, tmo_err, spi.wrt, cnv_cmplt}, 4'h0);
        check("rst_mid_wt", spi.wt_data, 16'h0000);
        mp = 2'd0;
        for (int i = 0; i < 4; i++) shadow[i] = 12'h0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        hold = 1'b0;
        @(negedge clk);
        conv(12'h5A5, 0);
        check("post_rst_ch", last_wt, 16'h0000);
        check("post_rst_regs", {lft_ld, rght_ld, steer_pot, batt}, {12'h5A5, 12'h0, 12'h0, 12'h0});
        check("final_queue", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
